// File: rtl/wb_rr_arbiter_pkg.sv
// Shared definitions for the round-robin Wishbone data-port arbiter:
// FSM state encodings and the owner-index width.
package wb_rr_arbiter_pkg;

  localparam int GNT_NUM_W = 3;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_ACTIVE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester searching upward
// (with wrap) from last+1; the last winner is checked last.
module rr_pick
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_M = 3
) (
  input  logic [NUM_M-1:0]     req,
  input  logic [GNT_NUM_W-1:0] last,
  output logic [NUM_M-1:0]     win_oh,
  output logic [GNT_NUM_W-1:0] win_idx
);

  logic found_s;
  logic hit_s;

  // Scan priority slots last+1 .. last+NUM_M; the first matching slot wins.
  always_comb begin
    win_oh  = {NUM_M{1'b0}};
    win_idx = {GNT_NUM_W{1'b0}};
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int k = 1; k <= NUM_M; k++) begin
      for (int i = 0; i < NUM_M; i++) begin
        hit_s     = !found_s && req[i] && (i == ((int'(last) + k) % NUM_M));
        win_oh[i] = win_oh[i] | hit_s;
        win_idx   = hit_s ? GNT_NUM_W'(i) : win_idx;
        found_s   = found_s | hit_s;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one classic Wishbone slave between NUM_M masters.
// Optional ack timeout is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_M          = 3,
  parameter int DW             = 32,
  parameter int AW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_M-1:0]     m_cyc_i,
  input  logic [NUM_M-1:0]     m_we_i,
  input  logic [NUM_M*AW-1:0]  m_adr_i,
  input  logic [NUM_M*DW-1:0]  m_dat_i,
  output logic [DW-1:0]        m_dat_o,
  output logic [NUM_M-1:0]     m_ack_o,
  output logic [NUM_M-1:0]     m_err_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  input  logic [DW-1:0]        s_dat_i,
  input  logic                 s_ack_i,
  output logic [NUM_M-1:0]     gnt_o,
  output logic [GNT_NUM_W-1:0] gnt_num_o,
  output logic                 busy_o
);

  arb_state_t           state_r;
  logic [GNT_NUM_W-1:0] last_r;
  logic [GNT_NUM_W-1:0] gnt_num_r;
  logic [NUM_M-1:0]     gnt_r;
  logic [NUM_M-1:0]     pick_oh_s;
  logic [GNT_NUM_W-1:0] pick_idx_s;
  logic                 active_s;
  logic                 own_cyc_s;
  logic [AW-1:0]        adr_s;
  logic [DW-1:0]        dat_s;
  logic                 we_s;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]       to_cnt_r;
  logic [NUM_M-1:0] err_r;
  assign m_err_o = err_r;
`else
  assign m_err_o = {NUM_M{1'b0}};
`endif

  rr_pick #(.NUM_M(NUM_M)) u_pick (
    .req     (m_cyc_i),
    .last    (last_r),
    .win_oh  (pick_oh_s),
    .win_idx (pick_idx_s)
  );

  assign active_s  = (state_r == ARB_ACTIVE);
  assign own_cyc_s = |(m_cyc_i & gnt_r);

  // Owner mux: one-hot AND-OR so an empty grant drives zeros onto the slave.
  always_comb begin
    adr_s = {AW{1'b0}};
    dat_s = {DW{1'b0}};
    we_s  = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      adr_s = adr_s | (m_adr_i[i*AW +: AW] & {AW{gnt_r[i]}});
      dat_s = dat_s | (m_dat_i[i*DW +: DW] & {DW{gnt_r[i]}});
      we_s  = we_s  | (m_we_i[i] & gnt_r[i]);
    end
  end

  // Strobe follows the owner's cyc so an abandoned cycle drops it immediately.
  assign s_cyc_o   = active_s;
  assign s_stb_o   = active_s & own_cyc_s;
  assign s_we_o    = we_s;
  assign s_adr_o   = adr_s;
  assign s_dat_o   = dat_s;
  assign m_dat_o   = s_dat_i;
  assign m_ack_o   = gnt_r & {NUM_M{s_ack_i}};
  assign gnt_o     = gnt_r;
  assign gnt_num_o = gnt_num_r;
  assign busy_o    = active_s;

  // Grant FSM: IDLE arbitrates, ACTIVE holds the owner until ack or abandon.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ARB_IDLE;
      last_r    <= GNT_NUM_W'(NUM_M - 1);
      gnt_r     <= {NUM_M{1'b0}};
      gnt_num_r <= {GNT_NUM_W{1'b0}};
`ifdef WB_ARB_TIMEOUT_EN
      to_cnt_r  <= 8'd0;
      err_r     <= {NUM_M{1'b0}};
`endif
    end else begin
`ifdef WB_ARB_TIMEOUT_EN
      err_r <= {NUM_M{1'b0}};
`endif
      case (state_r)
        ARB_IDLE: begin
          if (|m_cyc_i) begin
            gnt_r     <= pick_oh_s;
            gnt_num_r <= pick_idx_s;
            state_r   <= ARB_ACTIVE;
`ifdef WB_ARB_TIMEOUT_EN
            to_cnt_r  <= 8'd0;
`endif
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_ACTIVE: begin
          if (s_ack_i) begin
            last_r    <= gnt_num_r;
            gnt_r     <= {NUM_M{1'b0}};
            gnt_num_r <= {GNT_NUM_W{1'b0}};
            state_r   <= ARB_IDLE;
          end else if (!own_cyc_s) begin
            // Abandoned cycle: priority order is left untouched.
            gnt_r     <= {NUM_M{1'b0}};
            gnt_num_r <= {GNT_NUM_W{1'b0}};
            state_r   <= ARB_IDLE;
          end
`ifdef WB_ARB_TIMEOUT_EN
          else if (to_cnt_r == TO_LAST) begin
            err_r     <= gnt_r;
            last_r    <= gnt_num_r;
            gnt_r     <= {NUM_M{1'b0}};
            gnt_num_r <= {GNT_NUM_W{1'b0}};
            state_r   <= ARB_IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + 8'd1;
          end
`else
          else begin
            state_r <= ARB_ACTIVE;
          end
`endif
        end
        default: begin
          state_r   <= ARB_IDLE;
          gnt_r     <= {NUM_M{1'b0}};
          gnt_num_r <= {GNT_NUM_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter and its rr_pick selector.
module tb_wb_rr_arbiter;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  m_cyc, m_we;
  logic [95:0] m_adr, m_dat;
  logic [31:0] m_dat_o;
  logic [2:0]  m_ack, m_err;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat, s_dat_i;
  logic        s_ack;
  logic [2:0]  gnt, gnt_num;
  logic        busy;

  logic [3:0]  p_req, p_oh;
  logic [2:0]  p_last, p_idx;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.NUM_M(3), .DW(32), .AW(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc), .m_we_i(m_we), .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_dat_o(s_dat), .s_dat_i(s_dat_i), .s_ack_i(s_ack),
    .gnt_o(gnt), .gnt_num_o(gnt_num), .busy_o(busy)
  );

  rr_pick #(.NUM_M(4)) u_pick (
    .req(p_req), .last(p_last), .win_oh(p_oh), .win_idx(p_idx)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; m_cyc = 3'b000; m_we = 3'b000; m_dat = 96'd0;
    s_dat_i = 32'd0; s_ack = 1'b0;
    for (int i = 0; i < 3; i++) m_adr[i*32 +: 32] = 32'h100 * (i + 1);

    // rr_pick standalone
    p_req = 4'b0000; p_last = 3'd0; #1;
    chk("pick_none_oh", 64'(p_oh), 64'h0);
    p_req = 4'b1001; p_last = 3'd0; #1;
    chk("pick_wrap_idx", 64'(p_idx), 64'd3);
    p_req = 4'b1001; p_last = 3'd3; #1;
    chk("pick_last3_oh", 64'(p_oh), 64'b0001);
    p_req = 4'b0110; p_last = 3'd2; #1;
    chk("pick_skip_idx", 64'(p_idx), 64'd1);

    // Reset values
    tick(); tick();
    chk("rst_scyc", 64'(s_cyc), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sadr", 64'(s_adr), 64'd0);

    // Single request from master 1, ack on second ACTIVE cycle
    rst = 1'b1; m_cyc = 3'b010; #1;
    chk("t1_stb_pre", 64'(s_stb), 64'd0);
    tick();
    chk("t1_stb", 64'(s_stb), 64'd1);
    chk("t1_gnt_num", 64'(gnt_num), 64'd1);
    chk("t1_gnt", 64'(gnt), 64'b010);
    chk("t1_sadr", 64'(s_adr), 64'h200);
    chk("t1_ack_early", 64'(m_ack), 64'd0);
    tick();
    s_ack = 1'b1; s_dat_i = 32'h1234_5678; #1;
    chk("t1_ack", 64'(m_ack), 64'b010);
    chk("t1_mdat", 64'(m_dat_o), 64'h1234_5678);
    tick();
    s_ack = 1'b0; m_cyc = 3'b000; #1;
    chk("t1_scyc_after", 64'(s_cyc), 64'd0);
    chk("t1_ack_after", 64'(m_ack), 64'd0);

    // Asynchronous reset in the middle of an access
    m_cyc = 3'b010;
    tick();
    chk("rm_busy", 64'(busy), 64'd1);
    rst = 1'b0; s_ack = 1'b1; #1;
    chk("rm_scyc", 64'(s_cyc), 64'd0);
    chk("rm_sstb", 64'(s_stb), 64'd0);
    chk("rm_gnt", 64'(gnt), 64'd0);
    chk("rm_busy0", 64'(busy), 64'd0);
    chk("rm_sadr", 64'(s_adr), 64'd0);
    chk("rm_ack", 64'(m_ack), 64'd0);
    tick();

    // All three requesting, slave acks every ACTIVE cycle
    rst = 1'b1; m_cyc = 3'b111; s_ack = 1'b1; #1;
    chk("rr_idle_ack", 64'(m_ack), 64'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_gnt_num", 64'(gnt_num), 64'(k % 3));
      chk("rr_sadr", 64'(s_adr), 64'(32'h100 * ((k % 3) + 1)));
      chk("rr_ack", 64'(m_ack), 64'(3'b001 << (k % 3)));
      tick();
      chk("rr_gap_busy", 64'(busy), 64'd0);
    end
    m_cyc = 3'b000; s_ack = 1'b0;

    // Master 1 writes, master 2 reads back
    m_adr[32 +: 32] = 32'h40; m_dat[32 +: 32] = 32'hDEAD_BEEF;
    m_we = 3'b010; m_cyc = 3'b010;
    tick();
    chk("wr_gnt_num", 64'(gnt_num), 64'd1);
    chk("wr_we", 64'(s_we), 64'd1);
    chk("wr_adr", 64'(s_adr), 64'h40);
    chk("wr_dat", 64'(s_dat), 64'hDEAD_BEEF);
    s_ack = 1'b1; #1;
    chk("wr_ack", 64'(m_ack), 64'b010);
    tick();
    s_ack = 1'b0; m_cyc = 3'b100; m_we = 3'b000; m_adr[64 +: 32] = 32'h40;
    tick();
    chk("rd_gnt_num", 64'(gnt_num), 64'd2);
    chk("rd_we", 64'(s_we), 64'd0);
    chk("rd_adr", 64'(s_adr), 64'h40);
    s_dat_i = 32'hDEAD_BEEF; s_ack = 1'b1; #1;
    chk("rd_mdat", 64'(m_dat_o), 64'hDEAD_BEEF);
    chk("rd_ack", 64'(m_ack), 64'b100);
    tick();
    s_ack = 1'b0; m_cyc = 3'b000;

    // Master 0 abandons before ack; priority must not move
    m_cyc = 3'b001;
    tick();
    chk("ab_gnt", 64'(gnt), 64'b001);
    chk("ab_stb", 64'(s_stb), 64'd1);
    m_cyc = 3'b000; #1;
    chk("ab_stb_drop", 64'(s_stb), 64'd0);
    chk("ab_no_ack", 64'(m_ack), 64'd0);
    tick();
    chk("ab_idle", 64'(busy), 64'd0);
    chk("ab_err", 64'(m_err), 64'd0);
    m_cyc = 3'b011;
    tick();
    chk("ab_regrant", 64'(gnt_num), 64'd0);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; m_cyc = 3'b000;

`ifdef WB_ARB_TIMEOUT_EN
    // Master 2 never acked; master 0 pending behind it
    m_cyc = 3'b100;
    tick();
    chk("to_gnt_num", 64'(gnt_num), 64'd2);
    m_cyc = 3'b101;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("to_wait_busy", 64'(busy), 64'd1);
      chk("to_wait_err", 64'(m_err), 64'd0);
    end
    tick();
    chk("to_err", 64'(m_err), 64'b100);
    chk("to_released", 64'(s_cyc), 64'd0);
    tick();
    chk("to_next_gnt", 64'(gnt_num), 64'd0);
    chk("to_err_clear", 64'(m_err), 64'd0);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; m_cyc = 3'b000;
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone arbiter that shares the single data-memory slave port (`wb_ram` data side) between the J1 CPU cores.
- Each core issues single-beat classic Wishbone cycles. The arbiter registers a grant, routes the winner's address, data and write-enable to the slave, and returns ack only to the winner.
- Sits in `cpu_top` between the `wb_j1_cpu` instances and `wb_ram`. It also reports the current owner so debug/UART logic can tag accesses with a CPU number.

Parameters:
- NUM_M, 3, number of masters (2..8).
- DW, 32, data width.
- AW, 32, address width.
- TIMEOUT_CYCLES, 255, cycles a granted access may wait for ack (used only with `WB_ARB_TIMEOUT_EN`).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- m_cyc_i  in  NUM_M  per-master cycle request; bit i = master i.
- m_we_i  in  NUM_M  per-master write enable.
- m_adr_i  in  NUM_M*AW  packed addresses; master i at [i*AW +: AW].
- m_dat_i  in  NUM_M*DW  packed write data.
- m_dat_o  out  DW  slave read data, broadcast to all masters.
- m_ack_o  out  NUM_M  per-master ack.
- m_err_o  out  NUM_M  per-master timeout error (0 when feature is out).
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_we_o  out  1  slave write enable.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_dat_i  in  DW  slave read data.
- s_ack_i  in  1  slave ack.
- gnt_o  out  NUM_M  one-hot current owner; 0 when idle.
- gnt_num_o  out  3  binary owner index, valid when busy_o=1.
- busy_o  out  1  a grant is held.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-low; all state clears immediately on rst=0.
- Reset values:
  - s_cyc_o, s_stb_o, s_we_o = 0; s_adr_o, s_dat_o = 0.
  - m_ack_o, m_err_o, gnt_o = 0; gnt_num_o = 0; busy_o = 0.
  - Round-robin pointer last = NUM_M-1, so master 0 wins first.
- FSM states: IDLE, ACTIVE.
- IDLE:
  - If any m_cyc_i bit is set, select the first requesting master searching upward (with wrap) from last+1.
  - Register gnt_o/gnt_num_o and go to ACTIVE.
  - Latency: m_cyc_i high at edge N gives s_cyc_o/s_stb_o high after edge N+1.
- ACTIVE:
  - s_cyc_o = s_stb_o = 1; s_adr_o, s_dat_o, s_we_o are muxed combinationally from the granted master.
  - m_ack_o[g] = s_ack_i & gnt_o[g], combinational, same cycle as slave ack.
  - m_dat_o = s_dat_i, unregistered.
  - On s_ack_i: last = granted index, go to IDLE, clear grant. The next edge has s_cyc_o = 0 (one dead cycle between owners, guaranteed).
  - If the granted master drops m_cyc_i before ack: abandon. Go to IDLE, clear grant, do not update last, drop s_stb_o the same cycle the cyc drops (combinational gating).
- Fairness: a master that just completed is lowest priority next round. Three masters requesting continuously are served 0,1,2,0,...; each access costs at least 2 cycles (grant + ack cycle).
- Simultaneous events:
  - New requests arriving during ACTIVE wait.
  - An ack together with the owner's new request is treated as completion; the owner re-arbitrates from IDLE.
- s_ack_i while IDLE is ignored and produces no master ack.
- Reset mid-access: all outputs clear asynchronously; no ack is delivered.
- gnt_num_o is 3 bits regardless of NUM_M; upper bits are zero.

Optional Feature:
- Macro: `WB_ARB_TIMEOUT_EN`.
- With the macro defined:
  - An 8-bit counter clears on entering ACTIVE and increments each ACTIVE cycle without ack.
  - When the count reaches TIMEOUT_CYCLES, m_err_o[g] pulses 1 cycle, s_cyc_o/s_stb_o drop, last = g, and the FSM goes to IDLE.
- Without the macro: no counter exists, m_err_o is tied 0, and ACTIVE waits for ack indefinitely.

Decomposition:
- Shared package/include (`define.v` style): `ARB_IDLE`/`ARB_ACTIVE` state encodings and the gnt_num width constant (3).
- One natural sub-module, `rr_pick`: combinational round-robin selector. Inputs are the req vector and last index; outputs are a one-hot winner and its binary index. The bench tests it standalone.

Test Plan:
- Reset release, only m_cyc_i=3'b010, slave acks on the 2nd ACTIVE cycle: s_stb_o rises 1 cycle after request, gnt_num_o=1, m_ack_o=3'b010 for exactly 1 cycle, s_cyc_o=0 on the following cycle.
- All three m_cyc_i held high, slave acks every ACTIVE cycle: grant order 0,1,2,0,1,2; no master granted twice consecutively; s_adr_o matches the owner's packed address each time.
- Master 1 write (we=1, adr=0x40, dat=0xDEADBEEF), then master 2 read of 0x40 with s_dat_i=0xDEADBEEF: s_we_o/s_adr_o/s_dat_o correct; m_dat_o=0xDEADBEEF with m_ack_o=3'b100.
- Master 0 granted, drops m_cyc_i before ack: s_stb_o falls the same cycle, FSM returns to IDLE, no ack pulse, next grant still starts search from master 0 (last unchanged).
- `WB_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=4, slave never acks on a master 2 request: m_err_o=3'b100 pulses after 4 ACTIVE cycles, bus released, a pending master 0 is then granted.
- Assert rst=0 mid-ACTIVE: all outputs 0 asynchronously (before the next clk edge); after release, master 0 wins first.
